mips_multicycle_ctrl: RTL and testbench

- Moore-FSM main controller for the multicycle MIPS datapath.
- Successor to the single-cycle combinational main decoder. Sequences each instruction over 3-5 cycles and drives all datapath enables and muxes.
- Supports R-type, lw, sw, beq, addi and j. Opcode values are parametrised, and it flags illegal opcodes.
- Sits between the instruction register opcode field and the multicycle datapath; the ALU decoder consumes ALUOp.

---
 rtl/mips_multicycle_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Moore-FSM main controller for the multicycle MIPS datapath (R-type, lw, sw, beq, addi, j).
// Optional bne support is built when MCCTRL_BNE_EN is defined (adds OP_BNE and BranchNe).
module mips_multicycle_ctrl #(
  parameter int unsigned          OPCODE_W = 6,
  parameter int unsigned          STATE_W  = 4,
  parameter logic [OPCODE_W-1:0]  OP_RTYPE = 6'h00,
  parameter logic [OPCODE_W-1:0]  OP_LW    = 6'h23,
  parameter logic [OPCODE_W-1:0]  OP_SW    = 6'h2B,
  parameter logic [OPCODE_W-1:0]  OP_BEQ   = 6'h04,
  parameter logic [OPCODE_W-1:0]  OP_ADDI  = 6'h08,
  parameter logic [OPCODE_W-1:0]  OP_J     = 6'h02
`ifdef MCCTRL_BNE_EN
  , parameter logic [OPCODE_W-1:0] OP_BNE  = 6'h05
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                IorD,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [1:0]          PCSrc,
  output logic                Branch,
  output logic                PCWrite,
  output logic [STATE_W-1:0]  state,
  output logic                illegal_op
`ifdef MCCTRL_BNE_EN
  , output logic              BranchNe
`endif
);

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB,
    BEQ, ADDIEX, ADDIWB, JUMP
`ifdef MCCTRL_BNE_EN
    , BNE
`endif
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       branch;
    logic       pcwrite;
`ifdef MCCTRL_BNE_EN
    logic       branchne;
`endif
  } ctrl_t;

  state_t                cur;
  state_t                nxt;
  ctrl_t                 ctrl_q;
  logic [OPCODE_W-1:0]   op_q;
  logic                  illegal_q;
  logic                  bad_op;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alusrcb = 2'b01;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD:   c.iord = 1'b1;
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BEQ: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ADDIWB:  c.regwrite = 1'b1;
      JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
`ifdef MCCTRL_BNE_EN
      BNE: begin
        c.alusrca  = 1'b1;
        c.aluop    = 2'b01;
        c.pcsrc    = 2'b01;
        c.branchne = 1'b1;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt    = FETCH;
    bad_op = 1'b0;
    case (cur)
      FETCH:  nxt = DECODE;
      DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) nxt = MEMADR;
        else if (opcode == OP_RTYPE)            nxt = EXEC;
        else if (opcode == OP_BEQ)              nxt = BEQ;
        else if (opcode == OP_ADDI)             nxt = ADDIEX;
        else if (opcode == OP_J)                nxt = JUMP;
`ifdef MCCTRL_BNE_EN
        else if (opcode == OP_BNE)              nxt = BNE;
`endif
        else begin
          nxt    = FETCH;
          bad_op = 1'b1;
        end
      end
      // opcode may have moved on by now; use the copy captured in DECODE
      MEMADR: nxt = (op_q == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  nxt = MEMWB;
      EXEC:   nxt = ALUWB;
      ADDIEX: nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  // Outputs are registered as the decode of the state being entered, so they
  // stay a pure function of the current state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur       <= FETCH;
      ctrl_q    <= decode(FETCH);
      illegal_q <= 1'b0;
      op_q      <= '0;
    end else begin
      cur    <= nxt;
      ctrl_q <= decode(nxt);
      if (bad_op) illegal_q <= 1'b1;
      if (cur == DECODE) op_q <= opcode;
    end
  end

  // Write enables are gated by rst_n so an abandoned instruction never commits.
  assign IorD       = ctrl_q.iord;
  assign MemWrite   = ctrl_q.memwrite & rst_n;
  assign IRWrite    = ctrl_q.irwrite & rst_n;
  assign RegDst     = ctrl_q.regdst;
  assign MemtoReg   = ctrl_q.memtoreg;
  assign RegWrite   = ctrl_q.regwrite & rst_n;
  assign ALUSrcA    = ctrl_q.alusrca;
  assign ALUSrcB    = ctrl_q.alusrcb;
  assign ALUOp      = ctrl_q.aluop;
  assign PCSrc      = ctrl_q.pcsrc;
  assign Branch     = ctrl_q.branch & rst_n;
  assign PCWrite    = ctrl_q.pcwrite & rst_n;
  assign state      = cur;
  assign illegal_op = illegal_q;
`ifdef MCCTRL_BNE_EN
  assign BranchNe   = ctrl_q.branchne & rst_n;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares. Honours MCCTRL_BNE_EN for the bne sequence.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       branch;
    logic       pcwrite;
    logic       branchne;
  } tctrl_t;

  typedef struct {
    int     st;
    tctrl_t ctrl;
    logic   ill;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       Branch, PCWrite;
  logic [3:0] state;
  logic       illegal_op;
  logic       branch_ne;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;

  mips_multicycle_ctrl #(.OPCODE_W(6), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .Branch(Branch),
    .PCWrite(PCWrite), .state(state), .illegal_op(illegal_op)
`ifdef MCCTRL_BNE_EN
    , .BranchNe(branch_ne)
`endif
  );

`ifndef MCCTRL_BNE_EN
  assign branch_ne = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-written output table, one entry per state.
  function automatic tctrl_t exp_ctrl(input int st, input logic r);
    tctrl_t c;
    c = '0;
    case (st)
      0:  begin c.alusrcb = 2'b01; c.irwrite = 1; c.pcwrite = 1; end
      1:  c.alusrcb = 2'b11;
      2:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      3:  c.iord = 1;
      4:  begin c.memtoreg = 1; c.regwrite = 1; end
      5:  begin c.iord = 1; c.memwrite = 1; end
      6:  begin c.alusrca = 1; c.aluop = 2'b10; end
      7:  begin c.regdst = 1; c.regwrite = 1; end
      8:  begin c.alusrca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1; end
      9:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      10: c.regwrite = 1;
      11: begin c.pcsrc = 2'b10; c.pcwrite = 1; end
      12: begin c.alusrca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branchne = 1; end
      default: c = '0;
    endcase
    if (!r) begin
      c.irwrite = 0; c.pcwrite = 0; c.branch = 0;
      c.regwrite = 0; c.memwrite = 0; c.branchne = 0;
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, got, want);
    end
  endtask

  // One cycle: drive inputs just after the edge and queue what this cycle must show.
  task automatic step(input logic r, input logic [5:0] op, input int st, input logic ill);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n  = r;
    opcode = op;
    e.st   = st;
    e.ctrl = exp_ctrl(st, r);
    e.ill  = ill;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t   e;
    tctrl_t got;
    forever begin
      @(negedge clk);
      cycle++;
      if (q.size() > 0) begin
        e = q.pop_front();
        got = '{IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUOp, PCSrc, Branch, PCWrite, branch_ne};
        chk("state", 32'(state), 32'(e.st));
        chk("ctrl", 32'(got), 32'(e.ctrl));
        chk("illegal_op", 32'(illegal_op), 32'(e.ill));
      end
    end
  end

  initial begin : stim
    rst_n  = 1'b0;
    opcode = 6'h00;
    // reset for two cycles, then release: FETCH with IRWrite/PCWrite live
    step(0, 6'h00, 0, 0);
    step(0, 6'h00, 0, 0);
    // lw, with opcode changed away from lw after DECODE
    step(1, 6'h3F, 0, 0);
    step(1, 6'h23, 1, 0);
    step(1, 6'h2B, 2, 0);
    step(1, 6'h00, 3, 0);
    step(1, 6'h00, 4, 0);
    // R-type, sw, addi back to back
    step(1, 6'h04, 0, 0);
    step(1, 6'h00, 1, 0);
    step(1, 6'h23, 6, 0);
    step(1, 6'h23, 7, 0);
    step(1, 6'h00, 0, 0);
    step(1, 6'h2B, 1, 0);
    step(1, 6'h23, 2, 0);
    step(1, 6'h23, 5, 0);
    step(1, 6'h00, 0, 0);
    step(1, 6'h08, 1, 0);
    step(1, 6'h00, 9, 0);
    step(1, 6'h00, 10, 0);
    // beq then j
    step(1, 6'h00, 0, 0);
    step(1, 6'h04, 1, 0);
    step(1, 6'h00, 8, 0);
    step(1, 6'h00, 0, 0);
    step(1, 6'h02, 1, 0);
    step(1, 6'h00, 11, 0);
    // illegal opcode, then lw with the flag held
    step(1, 6'h00, 0, 0);
    step(1, 6'h3F, 1, 0);
    step(1, 6'h00, 0, 1);
    step(1, 6'h23, 1, 1);
    step(1, 6'h00, 2, 1);
    step(1, 6'h00, 3, 1);
    step(1, 6'h00, 4, 1);
    // lw interrupted by reset in MEMRD
    step(1, 6'h00, 0, 1);
    step(1, 6'h23, 1, 1);
    step(1, 6'h00, 2, 1);
    step(0, 6'h00, 3, 1);
    step(1, 6'h00, 0, 0);
    // lw interrupted by reset in MEMWB: RegWrite must be masked
    step(1, 6'h23, 1, 0);
    step(1, 6'h00, 2, 0);
    step(1, 6'h00, 3, 0);
    step(0, 6'h00, 4, 0);
    step(1, 6'h00, 0, 0);
    // opcode 0x05
    step(1, 6'h05, 1, 0);
`ifdef MCCTRL_BNE_EN
    step(1, 6'h00, 12, 0);
    step(1, 6'h00, 0, 0);
`else
    step(1, 6'h00, 0, 1);
`endif
    step(1, 6'h00, 1, 0 | 1'(`ifdef MCCTRL_BNE_EN 0 `else 1 `endif));

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
